// File: rtl/qpsk_pkg.sv
// Shared types for the QPSK symbol/lock stage: lock detector states and
// Gray-coded dibit constants for the hard slicer.
package qpsk_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2,
    FADE   = 2'd3
  } lock_state_t;

  localparam logic [1:0] DIBIT_PP = 2'b00;  // +I +Q
  localparam logic [1:0] DIBIT_PN = 2'b01;  // +I -Q
  localparam logic [1:0] DIBIT_NP = 2'b10;  // -I +Q
  localparam logic [1:0] DIBIT_NN = 2'b11;  // -I -Q

  function automatic logic [1:0] slice_dibit(input logic neg_i, input logic neg_q);
    logic [1:0] d;
    case ({neg_i, neg_q})
      2'b00:   d = DIBIT_PP;
      2'b01:   d = DIBIT_PN;
      2'b10:   d = DIBIT_NP;
      default: d = DIBIT_NN;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// 2-bit symbol FIFO, first-word-fall-through; a push into a full FIFO is
// accepted when a pop happens on the same cycle.
module sym_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       push,
  input  logic [1:0] din,
  input  logic       pop,
  output logic [1:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [1:0]  last_q;
  logic        do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // When empty the output keeps showing the most recently consumed symbol.
  assign dout    = empty ? last_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        last_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/qpsk_symbol_lock.sv
// Symbol decimator, hard slicer, windowed hysteretic lock detector and
// output symbol FIFO for the QPSK Costas loop back end.
module qpsk_symbol_lock
  import qpsk_pkg::*;
#(
  parameter int IQ_WIDTH    = 16,
  parameter int SPS         = 4,
  parameter int WIN_LOG2    = 8,
  parameter int THR_SHIFT   = 2,
  parameter int LOCK_WINS   = 3,
  parameter int UNLOCK_WINS = 2,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [IQ_WIDTH-1:0] i_in,
  input  logic signed [IQ_WIDTH-1:0] q_in,
  input  logic                       in_valid,
  input  logic [$clog2(SPS)-1:0]     sym_phase,
  input  logic                       clear,
  output logic [1:0]                 sym_data,
  output logic                       sym_valid,
  input  logic                       sym_ready,
  output logic                       locked,
  output logic                       overflow
);
  localparam int PW = $clog2(SPS);
  localparam int MW = IQ_WIDTH + 1;
  localparam int SW = MW + WIN_LOG2;
  localparam int TW = SW + THR_SHIFT;
  localparam logic [7:0] LOCK_CNT   = 8'(LOCK_WINS);
  localparam logic [7:0] UNLOCK_CNT = 8'(UNLOCK_WINS);

  function automatic logic [MW-1:0] sat_abs(input logic signed [IQ_WIDTH-1:0] x);
    logic [IQ_WIDTH-1:0] mag;
    if (x == {1'b1, {(IQ_WIDTH-1){1'b0}}}) mag = {1'b0, {(IQ_WIDTH-1){1'b1}}};
    else if (x[IQ_WIDTH-1])                mag = IQ_WIDTH'(-x);
    else                                   mag = x;
    return {1'b0, mag};
  endfunction

  logic [PW-1:0]       samp_cnt;
  logic                take;
  logic [MW-1:0]       a_abs, b_abs, e_val, m_val;
  logic                s1_valid;
  logic [1:0]          s1_dibit;
  logic [MW-1:0]       s1_e, s1_m;
  logic [SW-1:0]       err_sum, mag_sum, err_tot, mag_tot;
  logic [TW-1:0]       err_scaled;
  logic [WIN_LOG2-1:0] win_cnt;
  logic                win_done, win_good;
  lock_state_t         state_q, state_d;
  logic [7:0]          run_q, run_d;
  logic                fifo_push, fifo_full, fifo_empty;

  assign take = in_valid && (samp_cnt == sym_phase);

  always_comb begin
    a_abs = sat_abs(i_in);
    b_abs = sat_abs(q_in);
    e_val = (a_abs >= b_abs) ? a_abs - b_abs : b_abs - a_abs;
    m_val = a_abs + b_abs;
  end

  // The verdict includes the symbol currently in stage 1, so no symbol is lost
  // at the window boundary when the accumulators restart.
  assign err_tot    = err_sum + SW'(s1_e);
  assign mag_tot    = mag_sum + SW'(s1_m);
  assign err_scaled = TW'(err_tot) << THR_SHIFT;
  assign win_done   = s1_valid && (win_cnt == '1);
  assign win_good   = err_scaled < TW'(mag_tot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt <= '0;
      s1_valid <= 1'b0;
      s1_dibit <= '0;
      s1_e     <= '0;
      s1_m     <= '0;
      err_sum  <= '0;
      mag_sum  <= '0;
      win_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid) samp_cnt <= samp_cnt + PW'(1);
      if (clear) begin
        s1_valid <= 1'b0;
        err_sum  <= '0;
        mag_sum  <= '0;
        win_cnt  <= '0;
        overflow <= 1'b0;
      end else begin
        s1_valid <= take;
        if (take) begin
          s1_dibit <= slice_dibit(i_in[IQ_WIDTH-1], q_in[IQ_WIDTH-1]);
          s1_e     <= e_val;
          s1_m     <= m_val;
        end
        if (s1_valid) begin
          win_cnt <= win_cnt + WIN_LOG2'(1);
          err_sum <= win_done ? '0 : err_tot;
          mag_sum <= win_done ? '0 : mag_tot;
        end
        if (fifo_push && fifo_full && !sym_ready) overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      run_q   <= '0;
    end else if (clear) begin
      state_q <= SEARCH;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (win_done) begin
      case (state_q)
        SEARCH: if (win_good) begin
          if (LOCK_WINS == 1) state_d = LOCKED;
          else begin
            state_d = VERIFY;
            run_d   = 8'd1;
          end
        end
        VERIFY: if (win_good) begin
          run_d = run_q + 8'd1;
          if (run_q + 8'd1 == LOCK_CNT) state_d = LOCKED;
        end else state_d = SEARCH;
        LOCKED: if (!win_good) begin
          if (UNLOCK_WINS == 1) state_d = SEARCH;
          else begin
            state_d = FADE;
            run_d   = 8'd1;
          end
        end
        FADE: if (win_good) state_d = LOCKED;
        else begin
          run_d = run_q + 8'd1;
          if (run_q + 8'd1 == UNLOCK_CNT) state_d = SEARCH;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  assign locked    = (state_q == LOCKED) || (state_q == FADE);
  // Writes are gated by the registered state, not the one this window produces.
  assign fifo_push = s1_valid && locked;
  assign sym_valid = !fifo_empty;

  sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (fifo_push),
    .din   (s1_dibit),
    .pop   (sym_ready),
    .dout  (sym_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
